clock_wait_responder: RTL and testbench
=======================================

# clock_wait_responder

Synthesizable cycle-wait responder on the testbench clock: the consumer end of the clock the smoke bench drives (by the HDL clock generator or externally).
- Accepts a "wait N cycles" request from the tblink-rpc transactor side, counts clock edges, and returns a tagged completion with the cycle-count timestamp.
- Gives the Python side a cycle-accurate time-advance primitive that behaves identically regardless of which end generates `clock`.

## Interface
Parameters:
- COUNT_W, 32: width of requested cycle count
- TAG_W, 8: width of request tag
- TIME_W, 64: width of free-running cycle counter/timestamp

Ports:
- clock  in  1  bench clock, all logic on rising edge
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request offered
- req_ready  out  1  responder can accept
- req_cycles  in  COUNT_W  cycles to wait
- req_tag  in  TAG_W  caller tag, echoed in response
- abort  in  1  cancel outstanding wait, no response
- rsp_valid  out  1  completion offered
- rsp_ready  in  1  completion consumed
- rsp_tag  out  TAG_W  tag of completed request
- rsp_time  out  TIME_W  cycle_count value when rsp_valid rose
- cycle_count  out  TIME_W  free-running edges since reset

## Operation
- Reset values: req_ready=0 while reset asserted, 1 on first cycle after release. rsp_valid=0, rsp_tag=0, rsp_time=0, cycle_count=0. State=IDLE.
- cycle_count increments by 1 every rising edge out of reset. Wraps 2^TIME_W-1 -> 0 with no flag.
- States:
  - IDLE: req_ready=1. req_valid&req_ready latches req_cycles into remaining and req_tag into tag. Next state COUNT, or RESP when req_cycles==0.
  - COUNT: req_ready=0. remaining decrements each edge. When remaining==1, the next edge enters RESP.
  - RESP: rsp_valid=1. rsp_tag and rsp_time are held stable until rsp_valid&rsp_ready, then IDLE.
- At most one request outstanding. No request is accepted in the same cycle as a response handshake.
- abort:
  - Sampled in COUNT only: COUNT->IDLE, no response.
  - Ignored in IDLE and RESP; a completed response is never dropped.
  - abort and remaining==1 in the same cycle: abort wins.
- Arithmetic: remaining is COUNT_W unsigned. req_cycles=2^COUNT_W-1 is legal and waits that many edges.
- Reset mid-operation clears all state immediately (asynchronous). No response is produced for the in-flight request.

## Timing
- Acceptance edge E0, request N. rsp_valid rises at edge E0+max(N,1).
- rsp_time = cycle_count after that edge. Hence rsp_time − (cycle_count after E0) = max(N,1).
- rsp_valid, rsp_tag and rsp_time change only on the handshake edge or reset.
- req_ready returns to 1 the cycle after the response handshake. Minimum request-to-request spacing is N+2 cycles with rsp_ready tied high.
- No combinational path from any input to any output.

## Structure
- Package clock_wait_pkg: state enum (IDLE, COUNT, RESP), default widths as localparams.
- Single module. The free-running counter may be a sub-module `clock_cycle_counter` (TIME_W counter, async reset), shared later by other bench-side responders.

## Test plan
- Reset release, no requests, 100 cycles: cycle_count=100, rsp_valid=0, req_ready=1 throughout.
- req_cycles=5, tag=0x3A accepted at E0, rsp_ready=1: rsp_valid for one cycle at E0+5, rsp_tag=0x3A, rsp_time−accept time=5, req_ready=1 next cycle.
- req_cycles=0 and req_cycles=1: both give rsp_valid at E0+1. req_cycles=2 gives E0+2.
- rsp_ready held low 7 cycles after rsp_valid: outputs stable, req_ready=0, a pending req_valid is not accepted until after the handshake.
- req_cycles=10, abort at 4th COUNT cycle: no rsp_valid ever, req_ready=1 next cycle. Abort coinciding with remaining==1 also yields no response.
- Reset asserted mid-COUNT (asynchronous, between edges): rsp_valid, cycle_count and req_ready go to 0 immediately. After release, a new req_cycles=3 completes at E0+3.

Source files
------------

// File: rtl/clock_wait_pkg.sv
// Shared types and default widths for the bench-side cycle-wait responder.
package clock_wait_pkg;

    localparam int unsigned COUNT_W_DEF = 32;
    localparam int unsigned TAG_W_DEF   = 8;
    localparam int unsigned TIME_W_DEF  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        RESP  = 2'd2
    } state_e;

endpackage

// File: rtl/clock_cycle_counter.sv
// Free-running edge counter since reset; wraps silently at 2^TIME_W.
module clock_cycle_counter #(
    parameter int unsigned TIME_W = 64
) (
    input  logic              clock,
    input  logic              reset,
    output logic [TIME_W-1:0] count
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count + TIME_W'(1);
        end
    end

endmodule

// File: rtl/clock_wait_responder.sv
// Accepts a tagged "wait N cycles" request and answers with a timestamped
// completion max(N,1) edges after acceptance; abort cancels while counting.
module clock_wait_responder
    import clock_wait_pkg::*;
#(
    parameter int unsigned COUNT_W = COUNT_W_DEF,
    parameter int unsigned TAG_W   = TAG_W_DEF,
    parameter int unsigned TIME_W  = TIME_W_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [COUNT_W-1:0] req_cycles,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic               abort,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [TAG_W-1:0]   rsp_tag,
    output logic [TIME_W-1:0]  rsp_time,
    output logic [TIME_W-1:0]  cycle_count
);

    state_e             state_q;
    logic [COUNT_W-1:0] remaining_q;
    logic [TAG_W-1:0]   tag_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [TIME_W-1:0]  rsp_time_q;
    logic               req_ready_q;
    logic               rsp_valid_q;
    logic [TIME_W-1:0]  time_next;

    clock_cycle_counter #(
        .TIME_W (TIME_W)
    ) u_cycle_counter (
        .clock (clock),
        .reset (reset),
        .count (cycle_count)
    );

    // Value cycle_count will hold after the current edge.
    assign time_next = cycle_count + TIME_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            tag_q       <= '0;
            rsp_tag_q   <= '0;
            rsp_time_q  <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    req_ready_q <= 1'b1;
                    if (req_valid && req_ready_q) begin
                        tag_q       <= req_tag;
                        remaining_q <= req_cycles;
                        req_ready_q <= 1'b0;
                        state_q     <= (req_cycles == '0) ? RESP : COUNT;
                    end
                end
                COUNT: begin
                    if (abort) begin
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end else if (remaining_q == COUNT_W'(1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_tag_q   <= tag_q;
                        rsp_time_q  <= time_next;
                        state_q     <= RESP;
                    end else begin
                        remaining_q <= remaining_q - COUNT_W'(1);
                    end
                end
                RESP: begin
                    // A zero-cycle request arrives here unarmed and raises
                    // rsp_valid one edge later, matching a one-cycle wait.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_tag_q   <= tag_q;
                        rsp_time_q  <= time_next;
                    end else if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_time  = rsp_time_q;

endmodule

// File: tb/tb_clock_wait_responder.sv
// Directed plus randomized bench for clock_wait_responder against an
// arithmetic model: completion at accept time + max(N,1), echoed tag.
module tb_clock_wait_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_cycles = '0;
    logic [7:0]  req_tag = '0;
    logic        abort = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [7:0]  rsp_tag;
    logic [63:0] rsp_time;
    logic [63:0] cycle_count;

    int          checks = 0;
    int          errors = 0;
    longint      tcyc = 0;

    clock_wait_responder #(
        .COUNT_W (32),
        .TAG_W   (8),
        .TIME_W  (64)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_cycles  (req_cycles),
        .req_tag     (req_tag),
        .abort       (abort),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_tag     (rsp_tag),
        .rsp_time    (rsp_time),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock edge, then settle; tcyc tracks edges since reset release.
    task automatic step();
        @(posedge clock);
        #1;
        tcyc++;
    endtask

    task automatic run_req(input int n, input logic [7:0] tg, input int hold, input int abort_at);
        longint t0;
        longint due;
        int     w;
        w = 0;
        while (req_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        chk("ready_before_req", {63'd0, req_ready}, 64'd1);
        rsp_ready  = (hold == 0);
        req_valid  = 1'b1;
        req_cycles = 32'(n);
        req_tag    = tg;
        step();
        t0 = tcyc;
        req_valid = 1'b0;
        chk("ready_low_after_accept", {63'd0, req_ready}, 64'd0);
        due = t0 + ((n == 0) ? 1 : n);

        if (abort_at > 0) begin
            for (int k = 1; k < abort_at; k++) begin
                step();
                chk("no_rsp_before_abort", {63'd0, rsp_valid}, 64'd0);
            end
            abort = 1'b1;
            step();
            abort = 1'b0;
            chk("ready_after_abort", {63'd0, req_ready}, 64'd1);
            chk("no_rsp_on_abort", {63'd0, rsp_valid}, 64'd0);
            for (int k = 0; k < n + 2; k++) begin
                step();
                chk("no_rsp_after_abort", {63'd0, rsp_valid}, 64'd0);
            end
            return;
        end

        while (tcyc < due - 1) begin
            step();
            chk("early_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        step();
        chk("rsp_valid_rise", {63'd0, rsp_valid}, 64'd1);
        chk("rsp_tag", {56'd0, rsp_tag}, {56'd0, tg});
        chk("rsp_time", rsp_time, 64'(due));
        chk("rsp_latency", rsp_time - 64'(t0), 64'((n == 0) ? 1 : n));
        chk("cycle_count_at_rsp", cycle_count, 64'(tcyc));

        if (hold > 0) begin
            req_valid  = 1'b1;
            req_cycles = 32'd2;
            req_tag    = 8'hFF;
            for (int k = 0; k < hold; k++) begin
                step();
                chk("hold_valid", {63'd0, rsp_valid}, 64'd1);
                chk("hold_tag", {56'd0, rsp_tag}, {56'd0, tg});
                chk("hold_time", rsp_time, 64'(due));
                chk("hold_ready_low", {63'd0, req_ready}, 64'd0);
            end
            rsp_ready = 1'b1;
        end
        step();
        req_valid = 1'b0;
        chk("rsp_one_cycle", {63'd0, rsp_valid}, 64'd0);
        chk("ready_after_hs", {63'd0, req_ready}, 64'd1);
        chk("count_after_hs", cycle_count, 64'(tcyc));
    endtask

    initial begin
        int n;
        int ab;
        #3;
        chk("rst_req_ready", {63'd0, req_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_tag", {56'd0, rsp_tag}, 64'd0);
        chk("rst_rsp_time", rsp_time, 64'd0);
        chk("rst_cycle_count", cycle_count, 64'd0);
        #10;
        reset = 1'b0;
        tcyc  = 0;

        // Idle run: counter advances, nothing offered.
        for (int i = 0; i < 100; i++) begin
            step();
            chk("idle_ready", {63'd0, req_ready}, 64'd1);
            chk("idle_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        chk("idle_count_100", cycle_count, 64'd100);

        run_req(5, 8'h3A, 0, 0);
        run_req(0, 8'h10, 0, 0);
        run_req(1, 8'h11, 0, 0);
        run_req(2, 8'h12, 0, 0);
        run_req(4, 8'h77, 7, 0);
        run_req(10, 8'h55, 0, 4);
        run_req(3, 8'h56, 0, 3);
        run_req(0, 8'h57, 2, 0);

        for (int i = 0; i < 25; i++) begin
            n  = int'($urandom_range(0, 12));
            ab = 0;
            if (n > 0 && $urandom_range(0, 3) == 0) ab = int'($urandom_range(1, n));
            run_req(n, 8'($urandom), int'($urandom_range(0, 3)), ab);
        end

        // Asynchronous reset in the middle of a long wait.
        req_valid  = 1'b1;
        req_cycles = 32'd20;
        req_tag    = 8'hC3;
        step();
        req_valid = 1'b0;
        step();
        step();
        #3;
        reset = 1'b1;
        #1;
        chk("async_rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_rst_count", cycle_count, 64'd0);
        chk("async_rst_ready", {63'd0, req_ready}, 64'd0);
        #12;
        reset = 1'b0;
        tcyc  = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            chk("post_rst_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end
        chk("post_rst_count", cycle_count, 64'd25);
        run_req(3, 8'h99, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
